// File: rtl/intersection_scheduler.sv
// Two-direction traffic-light phase sequencer with per-second countdown,
// latched pedestrian requests, walk indicators and green truncation on cross-walk demand.
module intersection_scheduler #(
  parameter int GREEN_SEC  = 20,
  parameter int YELLOW_SEC = 3,
  parameter int ALLRED_SEC = 2,
  parameter int SHORT_SEC  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sec_tick,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk_ns,
  output logic       walk_ew,
  output logic [4:0] count,
  output logic [2:0] phase
);

  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] ALLRED_1  = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] ALLRED_2  = 3'd5;

  localparam logic [4:0] GREEN_C  = 5'(GREEN_SEC);
  localparam logic [4:0] YELLOW_C = 5'(YELLOW_SEC);
  localparam logic [4:0] ALLRED_C = 5'(ALLRED_SEC);
  localparam logic [4:0] SHORT_C  = 5'(SHORT_SEC);

  // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] LAMPS_ALLRED = 6'b001_001;

  logic [2:0] phase_reg, phase_next;
  logic [4:0] count_reg, count_next;
  logic       pend_ns_reg, pend_ns_next;
  logic       pend_ew_reg, pend_ew_next;
  logic       served_ns_reg, served_ns_next;
  logic       served_ew_reg, served_ew_next;
  logic [5:0] lamp_reg, lamp_next;
  logic [1:0] walk_reg, walk_next;
  logic       trunc;
  logic       enter_ns;
  logic       enter_ew;
  logic [2:0] succ;

  function automatic logic [4:0] phase_dur(input logic [2:0] p);
    case (p)
      NS_GREEN, EW_GREEN:   phase_dur = GREEN_C;
      NS_YELLOW, EW_YELLOW: phase_dur = YELLOW_C;
      default:              phase_dur = ALLRED_C;
    endcase
  endfunction

  // State register: every output is a flop, updated with the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg     <= ALLRED_2;
      count_reg     <= ALLRED_C;
      pend_ns_reg   <= 1'b0;
      pend_ew_reg   <= 1'b0;
      served_ns_reg <= 1'b0;
      served_ew_reg <= 1'b0;
      lamp_reg      <= LAMPS_ALLRED;
      walk_reg      <= 2'b00;
    end else begin
      phase_reg     <= phase_next;
      count_reg     <= count_next;
      pend_ns_reg   <= pend_ns_next;
      pend_ew_reg   <= pend_ew_next;
      served_ns_reg <= served_ns_next;
      served_ew_reg <= served_ew_next;
      lamp_reg      <= lamp_next;
      walk_reg      <= walk_next;
    end
  end

  // Next-state logic: recovery, truncation, then the tick-driven countdown.
  always_comb begin
    phase_next = phase_reg;
    count_next = count_reg;
    succ       = (phase_reg == ALLRED_2) ? NS_GREEN : phase_reg + 3'd1;
    trunc      = en && (count_reg > SHORT_C) &&
                 (((phase_reg == NS_GREEN) && pend_ew_reg) ||
                  ((phase_reg == EW_GREEN) && pend_ns_reg));
    if (phase_reg > ALLRED_2) begin
      phase_next = ALLRED_2;
      count_next = ALLRED_C;
    end else if (trunc) begin
      count_next = SHORT_C;
    end else if (en && sec_tick) begin
      if (count_reg > 5'd1) begin
        count_next = count_reg - 5'd1;
      end else begin
        phase_next = succ;
        count_next = phase_dur(succ);
      end
    end

    // Entry into a green clears its pending flag and decides whether walk is shown.
    enter_ns       = (phase_next == NS_GREEN) && (phase_reg != NS_GREEN);
    enter_ew       = (phase_next == EW_GREEN) && (phase_reg != EW_GREEN);
    pend_ns_next   = enter_ns ? 1'b0 : (pend_ns_reg | ped_req_ns);
    pend_ew_next   = enter_ew ? 1'b0 : (pend_ew_reg | ped_req_ew);
    served_ns_next = enter_ns ? (pend_ns_reg | ped_req_ns) : served_ns_reg;
    served_ew_next = enter_ew ? (pend_ew_reg | ped_req_ew) : served_ew_reg;
  end

  // Output logic, evaluated on the upcoming phase so outputs move with it.
  always_comb begin
    lamp_next = LAMPS_ALLRED;
    case (phase_next)
      NS_GREEN:  lamp_next = 6'b100_001;
      NS_YELLOW: lamp_next = 6'b010_001;
      EW_GREEN:  lamp_next = 6'b001_100;
      EW_YELLOW: lamp_next = 6'b001_010;
      default:   lamp_next = LAMPS_ALLRED;
    endcase
    walk_next = {served_ns_next && (phase_next == NS_GREEN),
                 served_ew_next && (phase_next == EW_GREEN)};
  end

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamp_reg;
  assign walk_ns = walk_reg[1];
  assign walk_ew = walk_reg[0];
  assign count   = count_reg;
  assign phase   = phase_reg;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler: phase timing, walk service,
// truncation, enable freeze, asynchronous reset and illegal-phase recovery.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sec_tick = 1'b0;
  logic       ped_req_ns = 1'b0;
  logic       ped_req_ew = 1'b0;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic       walk_ns, walk_ew;
  logic [4:0] count;
  logic [2:0] phase;
  logic [5:0] lamps;

  int n_cmp = 0;
  int n_err = 0;
  bit tick_run = 1'b0;
  bit tick_at_edge = 1'b0;

  intersection_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sec_tick   (sec_tick),
    .ped_req_ns (ped_req_ns),
    .ped_req_ew (ped_req_ew),
    .ns_g       (ns_g),
    .ns_y       (ns_y),
    .ns_r       (ns_r),
    .ew_g       (ew_g),
    .ew_y       (ew_y),
    .ew_r       (ew_r),
    .walk_ns    (walk_ns),
    .walk_ew    (walk_ew),
    .count      (count),
    .phase      (phase)
  );

  assign lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};

  initial forever #5 clk = ~clk;

  // One-clock tick every 10 clocks, changed on the falling edge.
  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      if (tick_run) begin
        c = (c == 9) ? 0 : c + 1;
        sec_tick = (c == 9);
      end else begin
        c = 0;
        sec_tick = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] exp_lamps(input logic [2:0] p);
    case (p)
      3'd0:    exp_lamps = 6'b100001;
      3'd1:    exp_lamps = 6'b010001;
      3'd3:    exp_lamps = 6'b001100;
      3'd4:    exp_lamps = 6'b001010;
      default: exp_lamps = 6'b001001;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    tick_at_edge = sec_tick;
    #1;
  endtask

  task automatic wait_enter(input logic [2:0] p, input int budget, output bit ok);
    int i;
    ok = 1'b0;
    for (i = 0; i < budget && phase == p; i++) step();
    for (; i < budget; i++) begin
      step();
      if (phase == p) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_count(input logic [2:0] p, input logic [4:0] c, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (phase == p && count == c) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (phase !== 3'd5) begin n_err++; $display("FAIL reset_phase: got %0d want 5", phase); end
    n_cmp++; if (count !== 5'd2) begin n_err++; $display("FAIL reset_count: got %0d want 2", count); end
    n_cmp++; if (lamps !== 6'b001001) begin n_err++; $display("FAIL reset_lamps: got %b want 001001", lamps); end
    n_cmp++; if ({walk_ns, walk_ew} !== 2'b00) begin n_err++; $display("FAIL reset_walk: got %b want 00", {walk_ns, walk_ew}); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    $display("reset: phase=%0d count=%0d lamps=%b", phase, count, lamps);
  endtask

  task automatic test_full_cycle();
    logic [2:0] exp_ph [6] = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    int         exp_dur [6] = '{2, 20, 3, 2, 20, 3};
    logic [2:0] prev;
    int idx, ticks;
    en = 1'b1;
    tick_run = 1'b1;
    idx = 0;
    ticks = 0;
    prev = phase;
    for (int i = 0; i < 800 && idx < 6; i++) begin
      step();
      if (tick_at_edge) ticks++;
      n_cmp++;
      if (lamps !== exp_lamps(phase)) begin
        n_err++; $display("FAIL cycle_lamps: phase=%0d got %b want %b", phase, lamps, exp_lamps(phase));
      end
      if (phase != prev) begin
        n_cmp++;
        if (prev !== exp_ph[idx] || ticks != exp_dur[idx]) begin
          n_err++; $display("FAIL cycle_phase_len: phase %0d lasted %0d ticks, want phase %0d for %0d", prev, ticks, exp_ph[idx], exp_dur[idx]);
        end
        $display("cycle: phase %0d lasted %0d ticks", prev, ticks);
        idx++;
        ticks = 0;
        prev = phase;
      end
      if (phase == 3'd0) begin
        n_cmp++;
        if (count !== 5'(20 - ticks)) begin
          n_err++; $display("FAIL cycle_ns_count: got %0d want %0d", count, 20 - ticks);
        end
      end
    end
    n_cmp++; if (idx < 6) begin n_err++; $display("FAIL cycle_timeout: completed %0d phases want 6", idx); end
  endtask

  task automatic test_ped_ns();
    bit ok;
    int n;
    wait_enter(3'd3, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pedns_wait_ew: got timeout want EW_GREEN"); end
    ped_req_ns = 1'b1;
    step();
    ped_req_ns = 1'b0;
    wait_enter(3'd0, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL pedns_wait_ns: got timeout want NS_GREEN"); end
    n_cmp++; if (dut.pend_ns_reg !== 1'b0) begin n_err++; $display("FAIL pedns_pend: got %b want 0", dut.pend_ns_reg); end
    n = 0;
    while (phase == 3'd0 && n < 400) begin
      n_cmp++; if (walk_ns !== 1'b1) begin n_err++; $display("FAIL pedns_walk: got %b want 1", walk_ns); end
      step();
      n++;
    end
    n_cmp++; if (phase !== 3'd1) begin n_err++; $display("FAIL pedns_next_phase: got %0d want 1", phase); end
    n_cmp++; if (walk_ns !== 1'b0) begin n_err++; $display("FAIL pedns_walk_off: got %b want 0", walk_ns); end
    $display("ped_ns: walk held %0d clocks in NS_GREEN", n);
  endtask

  task automatic test_truncate();
    bit ok;
    int ticks, n;
    wait_count(3'd0, 5'd15, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL trunc_wait: got timeout want NS_GREEN count 15"); end
    ped_req_ew = 1'b1;
    step();
    ped_req_ew = 1'b0;
    step();
    n_cmp++; if (count !== 5'd5) begin n_err++; $display("FAIL trunc_count: got %0d want 5", count); end
    ticks = 0;
    for (int i = 0; i < 200 && phase == 3'd0; i++) begin
      step();
      if (tick_at_edge) ticks++;
    end
    n_cmp++; if (phase !== 3'd1 || ticks != 5) begin n_err++; $display("FAIL trunc_len: phase %0d after %0d ticks want phase 1 after 5", phase, ticks); end
    wait_enter(3'd3, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL trunc_wait_ew: got timeout want EW_GREEN"); end
    n = 0;
    while (phase == 3'd3 && n < 400) begin
      n_cmp++; if (walk_ew !== 1'b1) begin n_err++; $display("FAIL trunc_walk_ew: got %b want 1", walk_ew); end
      step();
      n++;
    end
    $display("truncate: NS_GREEN ended %0d ticks after reload, walk_ew for %0d clocks", ticks, n);
  endtask

  task automatic test_no_trunc();
    bit ok;
    int ticks;
    wait_count(3'd0, 5'd4, 900, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL notrunc_wait: got timeout want NS_GREEN count 4"); end
    ped_req_ew = 1'b1;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      ped_req_ew = 1'b0;
      if (tick_at_edge) ticks++;
      if (phase != 3'd0) break;
      n_cmp++;
      if (count !== 5'(4 - ticks)) begin n_err++; $display("FAIL notrunc_count: got %0d want %0d", count, 4 - ticks); end
    end
    n_cmp++; if (ticks != 4 || phase !== 3'd1) begin n_err++; $display("FAIL notrunc_len: got %0d ticks phase %0d want 4 ticks phase 1", ticks, phase); end
    $display("no_trunc: NS_GREEN ran %0d more ticks", ticks);
  endtask

  task automatic test_enable();
    bit ok;
    wait_count(3'd0, 5'd7, 1000, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL en_wait: got timeout want NS_GREEN count 7"); end
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ped_req_ns = (i == 20);
      step();
      n_cmp++;
      if (count !== 5'd7 || lamps !== 6'b100001) begin
        n_err++; $display("FAIL en_hold: got count %0d lamps %b want 7 100001", count, lamps);
      end
    end
    ped_req_ns = 1'b0;
    en = 1'b1;
    wait_enter(3'd0, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL en_wait_ns: got timeout want NS_GREEN"); end
    n_cmp++; if (walk_ns !== 1'b1) begin n_err++; $display("FAIL en_walk_ns: got %b want 1", walk_ns); end
    $display("enable: frozen at count 7, request served walk_ns=%b", walk_ns);
  endtask

  task automatic test_async_reset();
    bit ok;
    wait_enter(3'd3, 800, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL arst_wait_ew: got timeout want EW_GREEN"); end
    ped_req_ns = 1'b1;
    step();
    ped_req_ns = 1'b0;
    n_cmp++; if (dut.pend_ns_reg !== 1'b1) begin n_err++; $display("FAIL arst_pend_set: got %b want 1", dut.pend_ns_reg); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (phase !== 3'd5 || count !== 5'd2) begin n_err++; $display("FAIL arst_state: got phase %0d count %0d want 5 2", phase, count); end
    n_cmp++; if (lamps !== 6'b001001 || {walk_ns, walk_ew} !== 2'b00) begin n_err++; $display("FAIL arst_outputs: got lamps %b walk %b want 001001 00", lamps, {walk_ns, walk_ew}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (dut.pend_ns_reg !== 1'b0) begin n_err++; $display("FAIL arst_pend_clear: got %b want 0", dut.pend_ns_reg); end
    wait_enter(3'd0, 400, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL arst_wait_ns: got timeout want NS_GREEN"); end
    n_cmp++; if (walk_ns !== 1'b0) begin n_err++; $display("FAIL arst_walk_ns: got %b want 0", walk_ns); end
    $display("async_reset: next NS_GREEN walk_ns=%b", walk_ns);
  endtask

  task automatic test_recover();
    dut.phase_reg = 3'd6;
    step();
    n_cmp++; if (phase !== 3'd5 || count !== 5'd2) begin n_err++; $display("FAIL recover_state: got phase %0d count %0d want 5 2", phase, count); end
    n_cmp++; if (lamps !== 6'b001001) begin n_err++; $display("FAIL recover_lamps: got %b want 001001", lamps); end
    $display("recover: phase=%0d count=%0d", phase, count);
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_ped_ns();
    test_truncate();
    test_no_trunc();
    test_enable();
    test_async_reset();
    test_recover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
